// File: rtl/hood_if.sv
// Request/status bundle between the key debouncers, the mode controller and
// the fan-driver / display consumers.
interface hood_if #(
  parameter int LW = 2,
  parameter int TW = 2
);
  logic          lvl_req;
  logic [LW-1:0] lvl_sel;
  logic          stop_req;
  logic          boost_req;
  logic          clean_req;
  logic [1:0]    state;
  logic [LW-1:0] level;
  logic [TW-1:0] remain_sec;
  logic          boost_used;
  logic [31:0]   work_sec;
  logic          reminder;
  logic          done_pulse;

  // Request side (debouncers / test driver)
  modport master (
    output lvl_req, lvl_sel, stop_req, boost_req, clean_req,
    input  state, level, remain_sec, boost_used, work_sec, reminder, done_pulse
  );

  // Controller side
  modport slave (
    input  lvl_req, lvl_sel, stop_req, boost_req, clean_req,
    output state, level, remain_sec, boost_used, work_sec, reminder, done_pulse
  );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: arbitrates level / stop / boost / self-clean
// requests, times the boost and clean modes in whole seconds, accumulates
// fan run time and raises a cleaning reminder.
module hood_mode_ctrl #(
  parameter int CLK_FREQ           = 100_000_000,
  parameter int NUM_LEVELS         = 3,
  parameter int BOOST_SECONDS      = 60,
  parameter int CLEAN_SECONDS      = 180,
  parameter int WORK_LIMIT_SECONDS = 36000
) (
  input logic  clk,
  input logic  rst,
  hood_if.slave bus
);

  localparam int LW          = $clog2(NUM_LEVELS + 1);
  localparam int MAX_SECONDS = (BOOST_SECONDS > CLEAN_SECONDS) ? BOOST_SECONDS : CLEAN_SECONDS;
  localparam int TW          = $clog2(MAX_SECONDS + 1);
  localparam int PW          = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEVEL = 2'd1,
    ST_BOOST = 2'd2,
    ST_CLEAN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] remain_q, remain_d;
  logic          boost_used_q, boost_used_d;
  logic [31:0]   work_q, work_d;
  logic          reminder_q, reminder_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s;
  logic          lvl_ok_s;
  logic          expire_s;

  assign tick_s   = (presc_q == PW'(CLK_FREQ - 1));
  assign lvl_ok_s = bus.lvl_req && (bus.lvl_sel != '0) && (bus.lvl_sel <= LW'(NUM_LEVELS));

  // Next-state, countdown, run-time and reminder computation
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    remain_d     = remain_q;
    boost_used_d = boost_used_q;
    work_d       = work_q;
    reminder_d   = reminder_q;
    done_d       = 1'b0;
    expire_s     = 1'b0;

    // Request arbitration: the highest-priority pulse present wins even if
    // it turns out to be ignored in the current mode; the rest are dropped.
    case (state_q)
      ST_IDLE: begin
        if (bus.lvl_req) begin
          if (lvl_ok_s) begin
            state_d = ST_LEVEL;
            level_d = bus.lvl_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.stop_req) begin
          state_d = ST_IDLE;
        end else if (bus.boost_req) begin
          if (!boost_used_q) begin
            state_d      = ST_BOOST;
            level_d      = LW'(NUM_LEVELS);
            remain_d     = TW'(BOOST_SECONDS);
            boost_used_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.clean_req) begin
          state_d  = ST_CLEAN;
          remain_d = TW'(CLEAN_SECONDS);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEVEL: begin
        if (bus.lvl_req) begin
          if (lvl_ok_s) begin
            level_d = bus.lvl_sel;
          end else begin
            level_d = level_q;
          end
        end else if (bus.stop_req) begin
          state_d = ST_IDLE;
          level_d = '0;
        end else begin
          state_d = ST_LEVEL;
        end
      end
      ST_BOOST, ST_CLEAN: begin
        if (tick_s) begin
          if (remain_q == TW'(1)) begin
            expire_s = 1'b1;
            done_d   = 1'b1;
            remain_d = '0;
            if (state_q == ST_BOOST) begin
              state_d = ST_LEVEL;
              level_d = LW'(NUM_LEVELS);
            end else begin
              state_d = ST_IDLE;
              level_d = '0;
            end
          end else begin
            remain_d = remain_q - TW'(1);
          end
        end else begin
          remain_d = remain_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
      end
    endcase

    // Run time counts whole seconds spent with the fan driven, saturating
    if (tick_s && ((state_q == ST_LEVEL) || (state_q == ST_BOOST)) && (work_q != 32'hFFFF_FFFF)) begin
      work_d = work_q + 32'd1;
    end else begin
      work_d = work_q;
    end

    // A finished clean resets the run-time account and the reminder
    if (expire_s && (state_q == ST_CLEAN)) begin
      work_d     = 32'd0;
      reminder_d = 1'b0;
    end else if (work_d >= 32'(WORK_LIMIT_SECONDS)) begin
      reminder_d = 1'b1;
    end else begin
      reminder_d = reminder_q;
    end

    // Prescaler restarts on every mode change so timed modes last exactly
    // SECONDS*CLK_FREQ cycles from their entry edge
    if ((state_d != state_q) || tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      remain_q     <= '0;
      boost_used_q <= 1'b0;
      work_q       <= 32'd0;
      reminder_q   <= 1'b0;
      done_q       <= 1'b0;
      presc_q      <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      remain_q     <= remain_d;
      boost_used_q <= boost_used_d;
      work_q       <= work_d;
      reminder_q   <= reminder_d;
      done_q       <= done_d;
      presc_q      <= presc_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.level      = level_q;
  assign bus.remain_sec = remain_q;
  assign bus.boost_used = boost_used_q;
  assign bus.work_sec   = work_q;
  assign bus.reminder   = reminder_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl: vector table, hand-written timed sequences and a
// randomized run against a cycle-count based reference model.
module tb_hood_mode_ctrl;

  localparam int CLK = 10;
  localparam int NL  = 3;
  localparam int BS  = 3;
  localparam int CS  = 2;
  localparam int WL  = 5;
  localparam int LW  = 2;
  localparam int TW  = 2;
  localparam longint WMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hood_if #(.LW(LW), .TW(TW)) bus ();

  hood_mode_ctrl #(
    .CLK_FREQ(CLK), .NUM_LEVELS(NL), .BOOST_SECONDS(BS),
    .CLEAN_SECONDS(CS), .WORK_LIMIT_SECONDS(WL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_req();
    bus.lvl_req   = 1'b0;
    bus.lvl_sel   = 2'd0;
    bus.stop_req  = 1'b0;
    bus.boost_req = 1'b0;
    bus.clean_req = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    clear_req();
  endtask

  task automatic do_reset();
    clear_req();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".state"},  64'(bus.state), 64'd0);
    chk({nm, ".level"},  64'(bus.level), 64'd0);
    chk({nm, ".remain"}, 64'(bus.remain_sec), 64'd0);
    chk({nm, ".used"},   64'(bus.boost_used), 64'd0);
    chk({nm, ".work"},   64'(bus.work_sec), 64'd0);
    chk({nm, ".rem"},    64'(bus.reminder), 64'd0);
    chk({nm, ".done"},   64'(bus.done_pulse), 64'd0);
  endtask

  // ---------------- reference model ----------------
  // Mode timing is derived from the number of cycles elapsed since the mode
  // was entered; a second lasts CLK cycles.
  int     m_mode;
  int     m_lvl;
  int     m_elapsed;
  bit     m_used;
  longint m_work;
  bit     m_rem;
  bit     m_done;

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_elapsed = 0; m_used = 1'b0;
    m_work = 0; m_rem = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input bit lr, input int ls, input bit sr, input bit br, input bit cr);
    int nm;
    bit sec_end;
    bit expire;
    bit ok;
    nm      = m_mode;
    sec_end = ((m_elapsed % CLK) == CLK - 1);
    expire  = 1'b0;
    m_done  = 1'b0;
    ok      = lr && (ls >= 1) && (ls <= NL);
    if (m_mode == 0) begin
      if (lr) begin
        if (ok) begin nm = 1; m_lvl = ls; end
      end else if (sr) begin
        nm = 0;
      end else if (br) begin
        if (!m_used) begin nm = 2; m_used = 1'b1; end
      end else if (cr) begin
        nm = 3;
      end
    end else if (m_mode == 1) begin
      if (lr) begin
        if (ok) m_lvl = ls;
      end else if (sr) begin
        nm = 0;
      end
    end else begin
      expire = (m_elapsed + 1 == ((m_mode == 2) ? BS : CS) * CLK);
    end
    if (sec_end && (m_mode == 1 || m_mode == 2) && m_work < WMAX) m_work++;
    if (expire) begin
      m_done = 1'b1;
      if (m_mode == 2) begin
        nm = 1; m_lvl = NL;
      end else begin
        nm = 0; m_work = 0; m_rem = 1'b0;
      end
    end
    if (!(expire && m_mode == 3) && m_work >= WL) m_rem = 1'b1;
    m_elapsed = (nm != m_mode) ? 0 : m_elapsed + 1;
    m_mode    = nm;
  endtask

  task automatic model_check(input int cyc);
    int exp_lvl;
    int exp_rem;
    exp_lvl = (m_mode == 1) ? m_lvl : (m_mode == 2) ? NL : 0;
    exp_rem = (m_mode == 2) ? BS - m_elapsed / CLK :
              (m_mode == 3) ? CS - m_elapsed / CLK : 0;
    chk($sformatf("rnd%0d.state", cyc),  64'(bus.state), 64'(m_mode));
    chk($sformatf("rnd%0d.level", cyc),  64'(bus.level), 64'(exp_lvl));
    chk($sformatf("rnd%0d.remain", cyc), 64'(bus.remain_sec), 64'(exp_rem));
    chk($sformatf("rnd%0d.used", cyc),   64'(bus.boost_used), 64'(m_used));
    chk($sformatf("rnd%0d.work", cyc),   64'(bus.work_sec), 64'(m_work));
    chk($sformatf("rnd%0d.rem", cyc),    64'(bus.reminder), 64'(m_rem));
    chk($sformatf("rnd%0d.done", cyc),   64'(bus.done_pulse), 64'(m_done));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         lr;
    logic [1:0] ls;
    bit         sr;
    bit         br;
    bit         cr;
    logic [1:0] st;
    logic [1:0] lv;
    bit         used;
  } vec_t;

  vec_t tbl[13];

  initial begin
    clear_req();
    // lr  ls  sr br cr   state level used
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0}; // enter level 2
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0}; // invalid sel ignored
    tbl[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0}; // level update
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 1'b0}; // boost ignored in LEVEL
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 1'b0}; // clean ignored in LEVEL
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0}; // lvl beats stop
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0}; // stop -> IDLE
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0}; // stop in IDLE ignored
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0}; // lvl beats boost/clean
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0}; // back to IDLE
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0}; // enter CLEAN
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0}; // lvl ignored in CLEAN
    tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0}; // boost ignored in CLEAN

    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      bus.lvl_req   = tbl[i].lr;
      bus.lvl_sel   = tbl[i].ls;
      bus.stop_req  = tbl[i].sr;
      bus.boost_req = tbl[i].br;
      bus.clean_req = tbl[i].cr;
      edge_step();
      chk($sformatf("vec%0d.state", i), 64'(bus.state), 64'(tbl[i].st));
      chk($sformatf("vec%0d.level", i), 64'(bus.level), 64'(tbl[i].lv));
      chk($sformatf("vec%0d.used", i),  64'(bus.boost_used), 64'(tbl[i].used));
    end

    // Boost expiry after exactly BS*CLK cycles
    do_reset();
    bus.boost_req = 1'b1;
    edge_step();
    chk("boost.entry.state",  64'(bus.state), 64'd2);
    chk("boost.entry.level",  64'(bus.level), 64'd3);
    chk("boost.entry.remain", 64'(bus.remain_sec), 64'd3);
    chk("boost.entry.used",   64'(bus.boost_used), 64'd1);
    repeat (10) edge_step();
    chk("boost.c10.remain", 64'(bus.remain_sec), 64'd2);
    repeat (19) edge_step();
    chk("boost.c29.state",  64'(bus.state), 64'd2);
    chk("boost.c29.remain", 64'(bus.remain_sec), 64'd1);
    chk("boost.c29.done",   64'(bus.done_pulse), 64'd0);
    edge_step();
    chk("boost.exp.state",  64'(bus.state), 64'd1);
    chk("boost.exp.level",  64'(bus.level), 64'd3);
    chk("boost.exp.remain", 64'(bus.remain_sec), 64'd0);
    chk("boost.exp.done",   64'(bus.done_pulse), 64'd1);
    edge_step();
    chk("boost.after.done", 64'(bus.done_pulse), 64'd0);
    bus.stop_req = 1'b1;
    edge_step();
    chk("boost.stop.state", 64'(bus.state), 64'd0);
    bus.boost_req = 1'b1;
    edge_step();
    chk("boost.again.state", 64'(bus.state), 64'd0);

    // Run time, reminder and self-clean
    do_reset();
    bus.lvl_req = 1'b1; bus.lvl_sel = 2'd1;
    edge_step();
    repeat (49) edge_step();
    chk("clean.c49.work", 64'(bus.work_sec), 64'd4);
    chk("clean.c49.rem",  64'(bus.reminder), 64'd0);
    edge_step();
    chk("clean.c50.work", 64'(bus.work_sec), 64'd5);
    chk("clean.c50.rem",  64'(bus.reminder), 64'd1);
    repeat (10) edge_step();
    chk("clean.c60.work", 64'(bus.work_sec), 64'd6);
    bus.stop_req = 1'b1;
    edge_step();
    bus.clean_req = 1'b1;
    edge_step();
    chk("clean.entry.state",  64'(bus.state), 64'd3);
    chk("clean.entry.remain", 64'(bus.remain_sec), 64'd2);
    repeat (5) edge_step();
    bus.lvl_req = 1'b1; bus.lvl_sel = 2'd2; bus.boost_req = 1'b1; bus.clean_req = 1'b1;
    edge_step();
    chk("clean.ign.state",  64'(bus.state), 64'd3);
    chk("clean.ign.remain", 64'(bus.remain_sec), 64'd2);
    repeat (4) edge_step();
    chk("clean.c10.remain", 64'(bus.remain_sec), 64'd1);
    repeat (9) edge_step();
    chk("clean.c19.state", 64'(bus.state), 64'd3);
    chk("clean.c19.work",  64'(bus.work_sec), 64'd6);
    edge_step();
    chk("clean.exp.state", 64'(bus.state), 64'd0);
    chk("clean.exp.work",  64'(bus.work_sec), 64'd0);
    chk("clean.exp.rem",   64'(bus.reminder), 64'd0);
    chk("clean.exp.done",  64'(bus.done_pulse), 64'd1);
    edge_step();
    chk("clean.after.done", 64'(bus.done_pulse), 64'd0);

    // Asynchronous reset in the middle of boost
    do_reset();
    bus.boost_req = 1'b1;
    edge_step();
    repeat (15) edge_step();
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.boost_req = 1'b1;
    edge_step();
    chk("midrst.reboost.state", 64'(bus.state), 64'd2);
    chk("midrst.reboost.used",  64'(bus.boost_used), 64'd1);

    // Run-time saturation
    do_reset();
    bus.lvl_req = 1'b1; bus.lvl_sel = 2'd2;
    edge_step();
    force dut.work_q = 32'hFFFF_FFFE;
    #1;
    release dut.work_q;
    repeat (10) edge_step();
    chk("sat.t1.work", 64'(bus.work_sec), 64'hFFFF_FFFF);
    repeat (20) edge_step();
    chk("sat.t3.work",  64'(bus.work_sec), 64'hFFFF_FFFF);
    chk("sat.t3.state", 64'(bus.state), 64'd1);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
        edge_step();
        rst = 1'b0;
      end else begin
        bus.lvl_req   = ($urandom_range(0, 5) == 0);
        bus.lvl_sel   = 2'($urandom_range(0, 3));
        bus.stop_req  = ($urandom_range(0, 7) == 0);
        bus.boost_req = ($urandom_range(0, 9) == 0);
        bus.clean_req = ($urandom_range(0, 9) == 0);
        model_edge(bus.lvl_req, int'(bus.lvl_sel), bus.stop_req, bus.boost_req, bus.clean_req);
        edge_step();
      end
      model_check(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
